wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter_pkg.sv | 22 ++
 rtl/wb_rr_arbiter_rr_priority_pick.sv | 40 ++++
 rtl/wb_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared interconnect definitions for the Wishbone round-robin arbiter:
// arbiter state encoding, timeout counter width and a counter helper.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_ERROR  = 2'b10
  } arb_state_e;

  localparam int TO_CNT_W = 16;

  // Saturating increment so the stall counter can never wrap back to zero.
  function automatic logic [TO_CNT_W-1:0] to_cnt_inc(input logic [TO_CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(TO_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: returns the first requesting index after
// 'last', wrapping modulo MASTER_COUNT, plus a flag telling whether any
// requester was found.
module rr_priority_pick #(
  parameter int MASTER_COUNT = 4,
  parameter int IDX_W        = $clog2(MASTER_COUNT)
) (
  input  logic [MASTER_COUNT-1:0] req,
  input  logic [IDX_W-1:0]        last,
  output logic                    any,
  output logic [IDX_W-1:0]        idx
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] cand_s;

  // Walk offsets from farthest to nearest so the nearest requester after 'last' is kept.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    sum_s  = '0;
    cand_s = '0;
    for (int off = MASTER_COUNT; off >= 1; off--) begin
      sum_s = {1'b0, last} + (IDX_W+1)'(off);
      if (sum_s >= (IDX_W+1)'(MASTER_COUNT)) begin
        sum_s = sum_s - (IDX_W+1)'(MASTER_COUNT);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDX_W-1:0];
      if (req[cand_s]) begin
        any = 1'b1;
        idx = cand_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone N:1 round-robin arbiter. One master owns the shared slave port for
// a whole bus cycle (cyc high); a stalled strobe beyond TIMEOUT_CYCLES forces
// a single error pulse to the owner and blanks the slave port until the owner
// releases cyc.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int MASTER_COUNT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic [MASTER_COUNT-1:0]            master_cyc,
  input  logic [MASTER_COUNT-1:0]            master_stb,
  input  logic [MASTER_COUNT-1:0]            master_we,
  input  logic [MASTER_COUNT*3-1:0]          master_tag,
  input  logic [MASTER_COUNT*DATA_WIDTH/8-1:0] master_sel,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] master_adr,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0] master_mosi,
  output logic [MASTER_COUNT*DATA_WIDTH-1:0] master_miso,
  output logic [MASTER_COUNT-1:0]            master_ack,
  output logic [MASTER_COUNT-1:0]            master_err,
  output logic                               slave_cyc,
  output logic                               slave_stb,
  output logic                               slave_we,
  output logic [2:0]                         slave_tag,
  output logic [DATA_WIDTH/8-1:0]            slave_sel,
  output logic [ADDR_WIDTH-1:0]              slave_adr,
  output logic [DATA_WIDTH-1:0]              slave_mosi,
  input  logic [DATA_WIDTH-1:0]              slave_miso,
  input  logic                               slave_ack,
  input  logic                               slave_err,
  output logic                               grant_valid,
  output logic [$clog2(MASTER_COUNT)-1:0]    grant_idx
);

  localparam int IDX_W = $clog2(MASTER_COUNT);
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int TAG_W = 3;
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);
  // Reset value of the last grant so that master 0 is the first winner.
  localparam logic [IDX_W-1:0]    LAST_RST = IDX_W'(MASTER_COUNT - 1);

  arb_state_e          state_r, state_next_s;
  logic [IDX_W-1:0]    grant_idx_r, grant_idx_next_s;
  logic [IDX_W-1:0]    last_grant_r, last_grant_next_s;
  logic                grant_valid_r, grant_valid_next_s;
  logic [TO_CNT_W-1:0] to_cnt_r, to_cnt_next_s;
  logic                err_first_r, err_first_next_s;

  logic [MASTER_COUNT-1:0] req_s;
  logic                    pick_any_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic                    owner_cyc_s;
  logic                    owner_stb_s;

  assign req_s       = master_cyc & master_stb;
  assign owner_cyc_s = master_cyc[grant_idx_r];
  assign owner_stb_s = master_stb[grant_idx_r];
  assign grant_valid = grant_valid_r;
  assign grant_idx   = grant_idx_r;

  rr_priority_pick #(
    .MASTER_COUNT (MASTER_COUNT),
    .IDX_W        (IDX_W)
  ) u_pick (
    .req  (req_s),
    .last (last_grant_r),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

  // Arbiter state register plus grant, last-grant, timeout and error-pulse registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r       <= ST_IDLE;
      grant_idx_r   <= '0;
      last_grant_r  <= LAST_RST;
      grant_valid_r <= 1'b0;
      to_cnt_r      <= '0;
      err_first_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      grant_idx_r   <= grant_idx_next_s;
      last_grant_r  <= last_grant_next_s;
      grant_valid_r <= grant_valid_next_s;
      to_cnt_r      <= to_cnt_next_s;
      err_first_r   <= err_first_next_s;
    end
  end

  // Next-state logic: grant in IDLE, hold/timeout in ACTIVE, wait for release in ERROR.
  always_comb begin
    state_next_s      = state_r;
    grant_idx_next_s  = grant_idx_r;
    last_grant_next_s = last_grant_r;
    to_cnt_next_s     = to_cnt_r;
    err_first_next_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        to_cnt_next_s = '0;
        if (pick_any_s) begin
          state_next_s     = ST_ACTIVE;
          grant_idx_next_s = pick_idx_s;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!owner_cyc_s) begin
          state_next_s      = ST_IDLE;
          last_grant_next_s = grant_idx_r;
          to_cnt_next_s     = '0;
        end else if (slave_ack || slave_err) begin
          // A response on the threshold cycle wins over the timeout.
          to_cnt_next_s = '0;
        end else if (to_cnt_r == TO_LIMIT) begin
          state_next_s     = ST_ERROR;
          err_first_next_s = 1'b1;
          to_cnt_next_s    = '0;
        end else if (owner_stb_s) begin
          to_cnt_next_s = to_cnt_inc(to_cnt_r);
        end else begin
          to_cnt_next_s = to_cnt_r;
        end
      end
      ST_ERROR: begin
        to_cnt_next_s = '0;
        if (!owner_cyc_s) begin
          state_next_s      = ST_IDLE;
          last_grant_next_s = grant_idx_r;
        end else begin
          state_next_s = ST_ERROR;
        end
      end
      default: begin
        state_next_s  = ST_IDLE;
        to_cnt_next_s = '0;
      end
    endcase
  end

  assign grant_valid_next_s = (state_next_s != ST_IDLE);

  // Bus routing: owner mirrored to slave in ACTIVE, one-cycle error pulse in ERROR, else all zero.
  always_comb begin
    slave_cyc   = 1'b0;
    slave_stb   = 1'b0;
    slave_we    = 1'b0;
    slave_tag   = '0;
    slave_sel   = '0;
    slave_adr   = '0;
    slave_mosi  = '0;
    master_ack  = '0;
    master_err  = '0;
    master_miso = '0;
    if (state_r == ST_ACTIVE) begin
      slave_cyc  = master_cyc[grant_idx_r];
      slave_stb  = master_stb[grant_idx_r];
      slave_we   = master_we[grant_idx_r];
      slave_tag  = master_tag[grant_idx_r*TAG_W +: TAG_W];
      slave_sel  = master_sel[grant_idx_r*SEL_W +: SEL_W];
      slave_adr  = master_adr[grant_idx_r*ADDR_WIDTH +: ADDR_WIDTH];
      slave_mosi = master_mosi[grant_idx_r*DATA_WIDTH +: DATA_WIDTH];
      master_ack[grant_idx_r] = slave_ack;
      master_err[grant_idx_r] = slave_err;
      master_miso[grant_idx_r*DATA_WIDTH +: DATA_WIDTH] = slave_miso;
    end else if (state_r == ST_ERROR) begin
      master_err[grant_idx_r] = err_first_r;
    end else begin
      master_err = '0;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus a randomized
// phase, all compared every cycle against a transaction-level reference model.
module tb_wb_rr_arbiter;

  localparam int M  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 8;
  localparam int IW = 2;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic [M-1:0]     master_cyc, master_stb, master_we;
  logic [M*3-1:0]   master_tag;
  logic [M*SW-1:0]  master_sel;
  logic [M*AW-1:0]  master_adr;
  logic [M*DW-1:0]  master_mosi;
  logic [M*DW-1:0]  master_miso;
  logic [M-1:0]     master_ack, master_err;
  logic             slave_cyc, slave_stb, slave_we;
  logic [2:0]       slave_tag;
  logic [SW-1:0]    slave_sel;
  logic [AW-1:0]    slave_adr;
  logic [DW-1:0]    slave_mosi;
  logic [DW-1:0]    slave_miso;
  logic             slave_ack, slave_err;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;

  wb_rr_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASTER_COUNT(M), .TIMEOUT_CYCLES(T)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .master_cyc(master_cyc), .master_stb(master_stb), .master_we(master_we),
    .master_tag(master_tag), .master_sel(master_sel), .master_adr(master_adr),
    .master_mosi(master_mosi), .master_miso(master_miso),
    .master_ack(master_ack), .master_err(master_err),
    .slave_cyc(slave_cyc), .slave_stb(slave_stb), .slave_we(slave_we),
    .slave_tag(slave_tag), .slave_sel(slave_sel), .slave_adr(slave_adr),
    .slave_mosi(slave_mosi), .slave_miso(slave_miso),
    .slave_ack(slave_ack), .slave_err(slave_err),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  // Free-running 100 MHz clock.
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner (-1 = bus free), whether the owner is in the
  // error phase, whether this is its first error cycle, stall count and
  // the last master that finished ownership.
  int m_owner, m_last, m_gidx, m_stall;
  bit m_in_err, m_err_first;

  task automatic model_reset();
    m_owner = -1; m_last = M - 1; m_gidx = 0; m_stall = 0;
    m_in_err = 1'b0; m_err_first = 1'b0;
  endtask

  task automatic model_step();
    if (m_owner < 0) begin
      for (int k = 1; k <= M; k++) begin
        if (master_cyc[(m_last + k) % M] && master_stb[(m_last + k) % M]) begin
          m_owner = (m_last + k) % M; m_gidx = m_owner; m_stall = 0;
          break;
        end
      end
    end else if (m_in_err) begin
      m_err_first = 1'b0;
      if (!master_cyc[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_in_err = 1'b0;
      end
    end else begin
      if (!master_cyc[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end else if (slave_ack || slave_err) begin
        m_stall = 0;
      end else if (m_stall == T) begin
        m_in_err = 1'b1; m_err_first = 1'b1;
      end else if (master_stb[m_owner]) begin
        m_stall++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [73:0]   e_req;
    logic [M-1:0]  e_ack, e_err;
    logic [M*DW-1:0] e_miso;
    e_req = '0; e_ack = '0; e_err = '0; e_miso = '0;
    if (m_owner >= 0 && !m_in_err) begin
      e_req = {master_cyc[m_owner], master_stb[m_owner], master_we[m_owner],
               master_tag[m_owner*3 +: 3], master_sel[m_owner*SW +: SW],
               master_adr[m_owner*AW +: AW], master_mosi[m_owner*DW +: DW]};
      e_ack[m_owner] = slave_ack;
      e_err[m_owner] = slave_err;
      e_miso[m_owner*DW +: DW] = slave_miso;
    end else if (m_owner >= 0 && m_err_first) begin
      e_err[m_owner] = 1'b1;
    end
    check("slave_req", 128'({slave_cyc, slave_stb, slave_we, slave_tag, slave_sel, slave_adr, slave_mosi}), 128'(e_req));
    check("master_ack", 128'(master_ack), 128'(e_ack));
    check("master_err", 128'(master_err), 128'(e_err));
    check("master_miso", 128'(master_miso), 128'(e_miso));
    check("grant_valid", 128'(grant_valid), 128'(m_owner >= 0));
    check("grant_idx", 128'(grant_idx), 128'(m_gidx));
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    @(negedge sys_clk);
    check_outputs();
    @(posedge sys_clk);
    if (sys_rst_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic set_m(input int m, input bit cyc, input bit stb, input logic [31:0] adr);
    master_cyc[m] = cyc;
    master_stb[m] = stb;
    master_we[m]  = 1'b0;
    master_tag[m*3 +: 3]   = 3'(m);
    master_sel[m*SW +: SW] = 4'hF;
    master_adr[m*AW +: AW] = adr;
    master_mosi[m*DW +: DW] = {16'hA5A5, 16'(m)};
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    master_cyc = '0; master_stb = '0; master_we = '0; master_tag = '0;
    master_sel = '0; master_adr = '0; master_mosi = '0;
    slave_miso = '0; slave_ack = 1'b0; slave_err = 1'b0;
    model_reset();
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  int           gcyc, err_at, err_cnt, errs, k, gap;
  bit           prev_gv;
  logic [M-1:0] drop;
  logic [5:0]   pat;
  int           order[$];
  bit           silent;

  initial begin
    do_reset();

    // Single request from master 2.
    set_m(2, 1'b1, 1'b1, 32'h0000_1000);
    #1 check("single_c1_idle", 128'(slave_cyc), 128'(1'b0));
    tick();
    slave_ack = 1'b1; slave_miso = 32'hCAFE_0002;
    #1;
    check("single_adr", 128'(slave_adr), 128'(32'h0000_1000));
    check("single_ack", 128'(master_ack), 128'(4'b0100));
    check("single_miso", 128'(master_miso), 128'({32'h0, 32'hCAFE_0002, 32'h0, 32'h0}));
    tick();
    set_m(2, 1'b0, 1'b0, 32'h0); slave_ack = 1'b0;
    tick(); tick();

    // Fairness: everyone requests, drops cyc for one cycle after each ack.
    do_reset();
    slave_ack = 1'b1; drop = '0; prev_gv = 1'b0; gap = 0;
    order.delete();
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      for (int m = 0; m < M; m++) set_m(m, !drop[m], !drop[m], 32'h100 * m);
      #1;
      if (grant_valid && !prev_gv) begin
        order.push_back(int'(grant_idx));
        if (order.size() > 1) check("fair_gap", 128'(gap), 128'(1));
        gap = 0;
      end else if (!grant_valid) begin
        gap++;
      end
      prev_gv = grant_valid;
      drop = master_ack & master_cyc;
      tick();
    end
    check("fair_count", 128'(order.size()), 128'(5));
    for (int i = 0; i < order.size(); i++) check("fair_order", 128'(order[i]), 128'(i % M));
    slave_ack = 1'b0;
    for (int m = 0; m < M; m++) set_m(m, 1'b0, 1'b0, 32'h0);
    tick(); tick(); tick();

    // Burst hold: master 1 keeps the grant through strobe gaps.
    do_reset();
    set_m(1, 1'b1, 1'b1, 32'h0000_0110);
    tick();
    set_m(0, 1'b1, 1'b1, 32'h0000_0100);
    pat = 6'b101001;
    for (int i = 0; i < 6; i++) begin
      master_stb[1] = pat[i]; slave_ack = pat[i];
      #1 check("burst_hold", 128'({grant_valid, grant_idx}), 128'({1'b1, 2'd1}));
      tick();
    end
    set_m(1, 1'b0, 1'b0, 32'h0); slave_ack = 1'b0; k = -1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (k < 0 && grant_valid && grant_idx == 2'd0) k = i;
      tick();
    end
    check("burst_regrant", 128'(k), 128'(2));
    set_m(0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Timeout: slave never answers.
    do_reset();
    set_m(0, 1'b1, 1'b1, 32'h0000_2000);
    gcyc = 0; err_at = -1; err_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (grant_valid) gcyc++;
      if (master_err[0]) begin err_cnt++; err_at = gcyc; end
      tick();
    end
    check("tmo_err_count", 128'(err_cnt), 128'(1));
    check("tmo_err_cycle", 128'(err_at), 128'(10));
    set_m(0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Ack lands exactly on the threshold cycle.
    do_reset();
    set_m(0, 1'b1, 1'b1, 32'h0000_3000);
    gcyc = 0; errs = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (grant_valid) gcyc++;
      slave_ack = (gcyc == 9);
      #1;
      if (gcyc == 9) check("thr_ack", 128'(master_ack), 128'(4'b0001));
      if (master_err != '0) errs++;
      tick();
    end
    slave_ack = 1'b0;
    #1;
    check("thr_active", 128'({grant_valid, slave_cyc}), 128'(2'b11));
    check("thr_noerr", 128'(errs), 128'(0));
    set_m(0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Reset pulse during an active transfer.
    do_reset();
    set_m(2, 1'b1, 1'b1, 32'h0000_4000);
    tick(); tick();
    set_m(0, 1'b1, 1'b1, 32'h0000_5000);
    slave_ack = 1'b1; slave_miso = 32'h1234_5678;
    #1 sys_rst_n = 1'b0;
    #1;
    check("rst_slave_zero", 128'({slave_cyc, slave_stb, slave_we, slave_tag, slave_sel, slave_adr, slave_mosi}), 128'(0));
    check("rst_master_zero", 128'({master_ack, master_err, master_miso}), 128'(0));
    check("rst_grant_zero", 128'({grant_valid, grant_idx}), 128'(0));
    model_reset();
    #1 sys_rst_n = 1'b1;
    slave_ack = 1'b0;
    tick();
    #1 check("rst_regrant", 128'({grant_valid, grant_idx}), 128'({1'b1, 2'd0}));
    set_m(0, 1'b0, 1'b0, 32'h0); set_m(2, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Randomized traffic with quiet-slave windows to provoke timeouts.
    do_reset();
    silent = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) silent = ($urandom_range(2) == 0);
      for (int m = 0; m < M; m++) begin
        if (!master_cyc[m]) master_cyc[m] = ($urandom_range(3) == 0);
        else                master_cyc[m] = ($urandom_range(15) != 0);
        master_stb[m] = master_cyc[m] && ($urandom_range(3) != 0);
        master_we[m]  = 1'($urandom_range(1));
        master_tag[m*3 +: 3]    = 3'($urandom_range(7));
        master_sel[m*SW +: SW]  = 4'($urandom_range(15));
        master_adr[m*AW +: AW]  = $urandom;
        master_mosi[m*DW +: DW] = $urandom;
      end
      slave_ack  = !silent && ($urandom_range(1) == 0);
      slave_err  = !silent && ($urandom_range(15) == 0);
      slave_miso = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
